buf_alloc_ctrl: RTL

- Allocation controller in front of the 4-entry LFU replacement finder.
- Arbitrates new-buffer requests from two requesters round-robin.
- Fills invalid buffers first; otherwise pulses the LFU for a victim, writes the victim back if it is dirty, then grants it.
- Tracks per-buffer valid/dirty state and drives the LFU's new-buffer request and reference inputs.

---
 rtl/buf_alloc_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/buf_alloc_ctrl.sv
// Buffer allocation controller: round-robin arbitration of two requesters, fill
// invalid buffers first, otherwise take an LFU victim and write it back if dirty.
module buf_alloc_ctrl #(
    parameter int NUM_BUF = 4,
    parameter int BUF_W   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         i_req,
    output logic [1:0]         o_gnt,
    output logic [BUF_W-1:0]   o_gnt_buf,
    input  logic               i_wr_mark,
    input  logic [BUF_W-1:0]   i_wr_buf,
    output logic               o_lfu_req,
    output logic [BUF_W-1:0]   o_lfu_ref,
    input  logic [BUF_W-1:0]   i_lfu_victim,
    output logic               o_wb_req,
    output logic [BUF_W-1:0]   o_wb_buf,
    input  logic               i_wb_ack,
    output logic               o_busy,
    output logic [NUM_BUF-1:0] o_valid_vec
);

    typedef enum logic [2:0] {IDLE, SEL, LAT, WB, GNT} state_t;

    state_t             r_state;
    logic               r_ptr;
    logic               r_win;
    logic [BUF_W-1:0]   r_victim;
    logic [NUM_BUF-1:0] r_valid;
    logic [NUM_BUF-1:0] r_dirty;
    logic [1:0]         r_gnt;
    logic [BUF_W-1:0]   r_gnt_buf;
    logic               r_lfu_req;
    logic [BUF_W-1:0]   r_lfu_ref;
    logic               r_wb_req;
    logic [BUF_W-1:0]   r_wb_buf;
    logic               r_busy;

    logic               w_pick;
    logic               w_all_valid;
    logic [BUF_W-1:0]   w_first_inv;
    logic [BUF_W-1:0]   w_cur_victim;
    logic               w_protect;

    assign w_pick      = i_req[r_ptr] ? r_ptr : ~r_ptr;
    assign w_all_valid = &r_valid;

    always_comb begin
        w_first_inv = '0;
        for (int i = NUM_BUF - 1; i >= 0; i--) begin
            if (!r_valid[i]) w_first_inv = BUF_W'(i);
        end
    end

    // In LAT the victim is still on the LFU port; afterwards it is latched.
    assign w_cur_victim = (r_state == LAT) ? i_lfu_victim : r_victim;
    assign w_protect    = ((r_state == LAT) || (r_state == WB) || (r_state == GNT)) &&
                          (i_wr_buf == w_cur_victim);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ptr     <= 1'b0;
            r_win     <= 1'b0;
            r_victim  <= '0;
            r_valid   <= '0;
            r_dirty   <= '0;
            r_gnt     <= '0;
            r_gnt_buf <= '0;
            r_lfu_req <= 1'b0;
            r_lfu_ref <= '0;
            r_wb_req  <= 1'b0;
            r_wb_buf  <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_gnt     <= '0;
            r_gnt_buf <= '0;
            r_lfu_req <= 1'b0;

            if (i_wr_mark && r_valid[i_wr_buf] && !w_protect)
                r_dirty[i_wr_buf] <= 1'b1;

            case (r_state)
                IDLE: begin
                    if (|i_req) begin
                        r_win     <= w_pick;
                        r_state   <= SEL;
                        r_busy    <= 1'b1;
                        // valid cannot change before SEL, so the LFU pulse can be decided now
                        r_lfu_req <= w_all_valid;
                    end
                end
                SEL: begin
                    if (!w_all_valid) begin
                        r_victim     <= w_first_inv;
                        r_gnt[r_win] <= 1'b1;
                        r_gnt_buf    <= w_first_inv;
                        r_state      <= GNT;
                    end else begin
                        r_state <= LAT;
                    end
                end
                LAT: begin
                    r_victim <= i_lfu_victim;
                    if (r_dirty[i_lfu_victim]) begin
                        r_wb_req <= 1'b1;
                        r_wb_buf <= i_lfu_victim;
                        r_state  <= WB;
                    end else begin
                        r_gnt[r_win] <= 1'b1;
                        r_gnt_buf    <= i_lfu_victim;
                        r_state      <= GNT;
                    end
                end
                WB: begin
                    if (i_wb_ack) begin
                        r_dirty[r_victim] <= 1'b0;
                        r_wb_req          <= 1'b0;
                        r_gnt[r_win]      <= 1'b1;
                        r_gnt_buf         <= r_victim;
                        r_state           <= GNT;
                    end
                end
                GNT: begin
                    r_valid[r_victim] <= 1'b1;
                    r_dirty[r_victim] <= 1'b0;
                    r_lfu_ref         <= r_victim;
                    r_ptr             <= ~r_win;
                    r_busy            <= 1'b0;
                    r_state           <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_gnt       = r_gnt;
    assign o_gnt_buf   = r_gnt_buf;
    assign o_lfu_req   = r_lfu_req;
    assign o_lfu_ref   = r_lfu_ref;
    assign o_wb_req    = r_wb_req;
    assign o_wb_buf    = r_wb_buf;
    assign o_busy      = r_busy;
    assign o_valid_vec = r_valid;

endmodule
